// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: Status/Cause/EPC/EBase, MMU fault registers,
// MTC0/MFC0 access, exception commit, ERET and the Count/Compare timer.
module cp0_regfile #(
  parameter int COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [2:0]  cp0_sel,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic        exc_commit,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_epc,
  input  logic        exc_bd,
  input  logic        badvaddr_we,
  input  logic [31:0] badvaddr_in,
  input  logic        context_we,
  input  logic [18:0] context_in,
  input  logic        entryhi_we,
  input  logic [18:0] entryhi_in,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic [31:0] status_out,
  output logic [31:0] cause_out,
  output logic [31:0] epc_out,
  output logic [31:0] ebase_out,
  output logic        timer_int
);

  localparam logic [4:0] A_CONTEXT  = 5'd4;
  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_ENTRYHI  = 5'd10;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;
  localparam logic [4:0] A_EBASE    = 5'd15;

  localparam int PW = (COUNT_DIV > 0) ? COUNT_DIV : 1;

  // Status fields
  logic        bev, erl, exl, ie;
  logic [7:0]  im;
  // Cause fields
  logic        bd, ti, iv;
  logic [5:0]  ip_hw;
  logic [1:0]  ip_sw;
  logic [4:0]  exc_code_q;
  // Other registers
  logic [31:0] epc, badvaddr, count, compare;
  logic [17:0] ebase_hi;
  logic [18:0] entryhi_vpn2, context_vpn2;
  logic [PW-1:0] presc;
  logic        presc_wrap;

  // MTC0 only lands when neither exception nor ERET commits this cycle
  logic mtc0_ok;
  logic wr_status, wr_cause, wr_epc, wr_ebase, wr_count, wr_compare;
  logic wr_entryhi, wr_context;

  assign mtc0_ok    = mtc0_we && !exc_commit && !eret;
  assign wr_status  = mtc0_ok && cp0_addr == A_STATUS  && cp0_sel == 3'd0;
  assign wr_cause   = mtc0_ok && cp0_addr == A_CAUSE   && cp0_sel == 3'd0;
  assign wr_epc     = mtc0_ok && cp0_addr == A_EPC     && cp0_sel == 3'd0;
  assign wr_ebase   = mtc0_ok && cp0_addr == A_EBASE   && cp0_sel == 3'd1;
  assign wr_count   = mtc0_ok && cp0_addr == A_COUNT   && cp0_sel == 3'd0;
  assign wr_compare = mtc0_ok && cp0_addr == A_COMPARE && cp0_sel == 3'd0;
  assign wr_entryhi = mtc0_ok && cp0_addr == A_ENTRYHI && cp0_sel == 3'd0;
  assign wr_context = mtc0_ok && cp0_addr == A_CONTEXT && cp0_sel == 3'd0;

  assign presc_wrap = (COUNT_DIV == 0) ? 1'b1 : (presc == {PW{1'b1}});

  // Architectural state: exception commit > ERET > MTC0
  always_ff @(posedge clk) begin
    if (reset) begin
      bev <= 1'b1; im <= '0; erl <= 1'b1; exl <= 1'b0; ie <= 1'b0;
      bd <= 1'b0; iv <= 1'b0; ip_hw <= '0; ip_sw <= '0; exc_code_q <= '0;
      epc <= '0; badvaddr <= '0; ebase_hi <= '0;
      entryhi_vpn2 <= '0; context_vpn2 <= '0;
    end else begin
      // Hardware interrupt pending bits track the lines with one cycle lag
      ip_hw <= {hw_int[5] | ti, hw_int[4:0]};
      if (exc_commit) begin
        exc_code_q <= exc_code;
        if (!exl) begin
          epc <= exc_epc;
          bd  <= exc_bd;
        end
        exl <= 1'b1;
        if (badvaddr_we) badvaddr     <= badvaddr_in;
        if (context_we)  context_vpn2 <= context_in;
        if (entryhi_we)  entryhi_vpn2 <= entryhi_in;
      end else if (eret) begin
        if (erl) erl <= 1'b0;
        else     exl <= 1'b0;
      end else begin
        if (wr_status) begin
          bev <= cp0_wdata[22];
          im  <= cp0_wdata[15:8];
          erl <= cp0_wdata[2];
          exl <= cp0_wdata[1];
          ie  <= cp0_wdata[0];
        end
        if (wr_cause) begin
          iv    <= cp0_wdata[23];
          ip_sw <= cp0_wdata[9:8];
        end
        if (wr_epc)     epc          <= cp0_wdata;
        if (wr_ebase)   ebase_hi     <= cp0_wdata[29:12];
        if (wr_entryhi) entryhi_vpn2 <= cp0_wdata[31:13];
        if (wr_context) context_vpn2 <= cp0_wdata[22:4];
      end
    end
  end

  // Count/Compare timer; a Compare write clears TI and beats a same-cycle match
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0; compare <= '0; presc <= '0; ti <= 1'b0;
    end else begin
      if (wr_count) begin
        count <= cp0_wdata;
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
        if (presc_wrap) count <= count + 32'd1;
      end
      if (wr_compare) begin
        compare <= cp0_wdata;
        ti      <= 1'b0;
      end else if (count == compare && compare != 32'd0) begin
        ti <= 1'b1;
      end
    end
  end

  assign status_out = {9'b0, bev, 6'b0, im, 5'b0, erl, exl, ie};
  assign cause_out  = {bd, ti, 6'b0, iv, 7'b0, ip_hw, ip_sw, 1'b0, exc_code_q, 2'b0};
  assign epc_out    = epc;
  assign ebase_out  = {2'b10, ebase_hi, 12'b0};
  assign timer_int  = ti;

  // MFC0 read mux; unimplemented registers read as zero
  always_comb begin
    cp0_rdata = '0;
    if (cp0_sel == 3'd0) begin
      case (cp0_addr)
        A_CONTEXT:  cp0_rdata = {9'b0, context_vpn2, 4'b0};
        A_BADVADDR: cp0_rdata = badvaddr;
        A_COUNT:    cp0_rdata = count;
        A_ENTRYHI:  cp0_rdata = {entryhi_vpn2, 13'b0};
        A_COMPARE:  cp0_rdata = compare;
        A_STATUS:   cp0_rdata = status_out;
        A_CAUSE:    cp0_rdata = cause_out;
        A_EPC:      cp0_rdata = epc;
        default:    cp0_rdata = '0;
      endcase
    end else if (cp0_sel == 3'd1 && cp0_addr == A_EBASE) begin
      cp0_rdata = ebase_out;
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: stimulus pushes expectations, a negedge
// monitor pops and compares against the selected DUT output.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic [2:0]  cp0_sel;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        exc_commit;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic        badvaddr_we;
  logic [31:0] badvaddr_in;
  logic        context_we;
  logic [18:0] context_in;
  logic        entryhi_we;
  logic [18:0] entryhi_in;
  logic        eret;
  logic [5:0]  hw_int;
  logic [31:0] status_out, cause_out, epc_out, ebase_out;
  logic        timer_int;

  cp0_regfile #(.COUNT_DIV(1)) dut (
    .clk(clk), .reset(reset), .mtc0_we(mtc0_we), .cp0_addr(cp0_addr),
    .cp0_sel(cp0_sel), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
    .exc_commit(exc_commit), .exc_code(exc_code), .exc_epc(exc_epc),
    .exc_bd(exc_bd), .badvaddr_we(badvaddr_we), .badvaddr_in(badvaddr_in),
    .context_we(context_we), .context_in(context_in),
    .entryhi_we(entryhi_we), .entryhi_in(entryhi_in), .eret(eret),
    .hw_int(hw_int), .status_out(status_out), .cause_out(cause_out),
    .epc_out(epc_out), .ebase_out(ebase_out), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  // Output selectors for the monitor
  localparam int S_RD = 0, S_STATUS = 1, S_CAUSE = 2, S_EPC = 3, S_EBASE = 4, S_TI = 5;

  typedef struct {
    string       name;
    int          src;
    logic [31:0] exp;
    logic [31:0] mask;
  } exp_t;

  exp_t exp_q[$];
  logic chk = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Monitor: on every flagged cycle pop one expectation and compare
  always @(negedge clk) begin
    if (chk) begin
      exp_t e;
      logic [31:0] act;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL no_expectation: check strobe with empty queue");
      end else begin
        e = exp_q.pop_front();
        case (e.src)
          S_RD:     act = cp0_rdata;
          S_STATUS: act = status_out;
          S_CAUSE:  act = cause_out;
          S_EPC:    act = epc_out;
          S_EBASE:  act = ebase_out;
          default:  act = {31'b0, timer_int};
        endcase
        if ((act & e.mask) !== (e.exp & e.mask)) begin
          bad++;
          $display("FAIL %s: got 0x%08h want 0x%08h (mask 0x%08h)", e.name, act, e.exp, e.mask);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe one output in the current cycle, then advance one edge
  task automatic expect_out(input string name, input int src, input logic [31:0] exp,
                            input logic [31:0] mask = 32'hFFFF_FFFF);
    exp_t e;
    e.name = name; e.src = src; e.exp = exp; e.mask = mask;
    exp_q.push_back(e);
    chk = 1'b1;
    tick();
    chk = 1'b0;
  endtask

  task automatic expect_rd(input string name, input logic [4:0] a, input logic [2:0] s,
                           input logic [31:0] exp);
    cp0_addr = a;
    cp0_sel  = s;
    expect_out(name, S_RD, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    mtc0_we = 1'b1; cp0_addr = a; cp0_sel = s; cp0_wdata = d;
    tick();
    mtc0_we = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] epc, input logic bdv);
    exc_commit = 1'b1; exc_code = code; exc_epc = epc; exc_bd = bdv;
    tick();
    exc_commit = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mtc0_we = 0; cp0_addr = 0; cp0_sel = 0; cp0_wdata = 0;
    exc_commit = 0; exc_code = 0; exc_epc = 0; exc_bd = 0;
    badvaddr_we = 0; badvaddr_in = 0; context_we = 0; context_in = 0;
    entryhi_we = 0; entryhi_in = 0; eret = 0; hw_int = 0;
    #1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    expect_rd("rst_status_rd", 5'd12, 3'd0, 32'h0040_0004);
    expect_rd("rst_ebase_rd", 5'd15, 3'd1, 32'h8000_0000);
    expect_out("rst_cause", S_CAUSE, 32'h0);
    expect_out("rst_epc", S_EPC, 32'h0);
    expect_out("rst_ti", S_TI, 32'h0);

    // Status write mask
    mtc0(5'd12, 3'd0, 32'hFFFF_FFFF);
    expect_rd("status_mask", 5'd12, 3'd0, 32'h0040_FF07);

    // EBase write mask, BadVAddr read-only
    mtc0(5'd15, 3'd1, 32'hFFFF_FFFF);
    expect_rd("ebase_mask", 5'd15, 3'd1, 32'hBFFF_F000);
    expect_out("ebase_out", S_EBASE, 32'hBFFF_F000);
    mtc0(5'd8, 3'd0, 32'h0000_1234);
    expect_rd("badvaddr_ro", 5'd8, 3'd0, 32'h0);
    expect_rd("unimpl_reg", 5'd3, 3'd0, 32'h0);

    // Cause software bits and hw_int in the same cycle, then hw lag
    hw_int = 6'h15;
    mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
    hw_int = 6'h00;
    expect_rd("cause_sw_hw", 5'd13, 3'd0, 32'h0080_5700);
    expect_out("cause_hw_lag", S_CAUSE, 32'h0080_0300);
    mtc0(5'd13, 3'd0, 32'h0);

    // First exception with EXL=0
    mtc0(5'd12, 3'd0, 32'h0);
    exc(5'd8, 32'hBFC0_0100, 1'b1);
    expect_out("exc1_epc", S_EPC, 32'hBFC0_0100);
    expect_out("exc1_cause", S_CAUSE, 32'h8000_0020);
    expect_out("exc1_status", S_STATUS, 32'h0000_0002);

    // Nested exception: EPC and BD held
    exc(5'd8, 32'h0000_1234, 1'b0);
    expect_out("exc2_epc_hold", S_EPC, 32'hBFC0_0100);
    expect_out("exc2_cause_hold", S_CAUSE, 32'h8000_0020);

    // MMU fault register updates
    badvaddr_we = 1; badvaddr_in = 32'h8000_2003;
    context_we = 1; context_in = 19'h40001;
    entryhi_we = 1; entryhi_in = 19'h40001;
    exc(5'd2, 32'h0, 1'b0);
    badvaddr_we = 0; context_we = 0; entryhi_we = 0;
    expect_rd("badvaddr_upd", 5'd8, 3'd0, 32'h8000_2003);
    expect_rd("context_upd", 5'd4, 3'd0, 32'h0040_0010);
    expect_rd("entryhi_upd", 5'd10, 3'd0, 32'h8000_2000);

    // Priority: exception beats ERET and MTC0
    mtc0(5'd12, 3'd0, 32'h0000_0004);
    eret = 1; mtc0_we = 1; cp0_addr = 5'd12; cp0_sel = 3'd0; cp0_wdata = 32'hFFFF_FFFF;
    exc(5'd4, 32'h0000_0100, 1'b0);
    eret = 0; mtc0_we = 0;
    expect_out("prio_status", S_STATUS, 32'h0000_0006);
    expect_out("prio_epc", S_EPC, 32'h0000_0100);
    expect_out("prio_cause", S_CAUSE, 32'h0000_0010);

    // ERET: ERL first, then EXL
    eret = 1; tick(); eret = 0;
    expect_out("eret_erl", S_STATUS, 32'h0000_0002);
    eret = 1; tick(); eret = 0;
    expect_out("eret_exl", S_STATUS, 32'h0000_0000);

    // Timer: Count=0 at edge E0, Compare=5 at E1; count hits 5 after E10, TI after E11
    mtc0(5'd9, 3'd0, 32'h0);
    mtc0(5'd11, 3'd0, 32'h5);
    repeat (9) tick();
    expect_out("ti_not_yet", S_TI, 32'h0);
    expect_out("ti_set", S_TI, 32'h1);
    expect_out("cause_ti_ip7", S_CAUSE, 32'h4000_8000, 32'h4000_8000);
    mtc0(5'd11, 3'd0, 32'd100);
    expect_out("ti_clear", S_TI, 32'h0);

    // Count wrap
    mtc0(5'd9, 3'd0, 32'hFFFF_FFFF);
    expect_rd("count_max0", 5'd9, 3'd0, 32'hFFFF_FFFF);
    expect_rd("count_max1", 5'd9, 3'd0, 32'hFFFF_FFFF);
    expect_rd("count_wrap", 5'd9, 3'd0, 32'h0);

    // Reset overrides same-cycle strobes
    mtc0(5'd12, 3'd0, 32'h0000_0001);
    reset = 1; exc_commit = 1; exc_epc = 32'hDEAD_BEEF;
    mtc0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'hFFFF_FFFF;
    tick();
    reset = 0; exc_commit = 0; mtc0_we = 0;
    expect_out("rst_mid_status", S_STATUS, 32'h0040_0004);
    expect_out("rst_mid_epc", S_EPC, 32'h0);
    expect_out("rst_mid_cause", S_CAUSE, 32'h0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file for the MIPS core. It sits directly downstream of the exception prioritiser and consumes that block's exception-commit bundle (exception flag, ExcCode, EPC, BadVAddr/Context/EntryHi updates). It also serves MTC0/MFC0 and ERET, and runs the Count/Compare timer. Its Status, Cause, EPC and EBase outputs feed back to the prioritiser.

## Interface
Parameters:
- COUNT_DIV, 1: Count increments once every 2^COUNT_DIV cycles (1 gives half rate).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- mtc0_we  in  1  write strobe for MTC0
- cp0_addr  in  5  register number for MTC0/MFC0
- cp0_sel  in  3  select field; only EBase uses sel=1
- cp0_wdata  in  32  MTC0 data
- cp0_rdata  out  32  MFC0 data, combinational
- exc_commit  in  1  exception commit, driven by the prioritiser's is_exception_to_cp0
- exc_code  in  5  ExcCode to record
- exc_epc  in  32  EPC, already adjusted for delay slot
- exc_bd  in  1  faulting instruction is in a delay slot
- badvaddr_we  in  1  BadVAddr update enable
- badvaddr_in  in  32  BadVAddr update data
- context_we  in  1  Context.BadVPN2 update enable
- context_in  in  19  Context.BadVPN2 update data
- entryhi_we  in  1  EntryHi.VPN2 update enable
- entryhi_in  in  19  EntryHi.VPN2 update data
- eret  in  1  ERET commit
- hw_int  in  6  level-sensitive hardware interrupt lines
- status_out  out  32  Status register
- cause_out  out  32  Cause register
- epc_out  out  32  EPC register; also the ERET target
- ebase_out  out  32  EBase register
- timer_int  out  1  Cause.TI

## Operation
- Registers and addresses: BadVAddr(8), Count(9), EntryHi(10, VPN2 at [31:13]), Compare(11), Status(12), Cause(13), EPC(14), EBase(15 sel 1), Context(4, BadVPN2 at [22:4]).
- Unimplemented registers and unimplemented bits read as 0.
- Status writable bits:
  - BEV[22]
  - IM[15:8]
  - ERL[2]
  - EXL[1]
  - IE[0]
- Cause bits:
  - Writable by MTC0: IV[23] and IP[9:8] only.
  - IP[15:10] are loaded every cycle: IP[14:10] from hw_int[4:0], IP[15] from hw_int[5] | TI.
  - TI[30], BD[31] and ExcCode[6:2] are written only by hardware.
- EBase: only bits [29:12] are writable; bits [31:30] are fixed at 2'b10.
- BadVAddr is read-only to MTC0.
- Update priority in one cycle is exc_commit > eret > mtc0_we.
  - The losing write is dropped.
  - badvaddr_we, context_we and entryhi_we apply only when exc_commit=1.
- exc_commit:
  - Cause.ExcCode ← exc_code.
  - If Status.EXL was 0: EPC ← exc_epc and Cause.BD ← exc_bd.
  - If Status.EXL was 1: EPC and BD are held.
  - Status.EXL ← 1.
  - Apply each enabled BadVAddr, Context or EntryHi update.
- eret:
  - If ERL=1, clear ERL; otherwise clear EXL.
  - The ERET target is epc_out as sampled in the same cycle.
- Timer:
  - Count increments when the prescaler wraps.
  - An MTC0 to Count loads the value and resets the prescaler.
  - When Count == Compare and Compare != 0, TI is set; the compare is checked every cycle.
  - An MTC0 to Compare clears TI.
  - TI set and Compare-write clear in the same cycle: the clear wins.

## Timing
- All writes are visible on outputs and cp0_rdata one cycle after the strobe. There is no write-to-read bypass.
- Reset values:
  - Status = 0x0040_0004 (BEV=1, ERL=1).
  - Cause, EPC, BadVAddr, Count, Compare, EntryHi and Context = 0.
  - EBase = 0x8000_0000.
  - timer_int = 0 and the prescaler = 0.
- Reset asserted mid-operation overrides every strobe in that cycle.
- Count wraps 0xFFFF_FFFF → 0 silently.
- Cause.IP[15:10] lag hw_int by exactly one cycle.
- An MTC0 to Cause.IP[9:8] together with hw_int changes in the same cycle: both take effect; the bit fields are disjoint.

## Test plan
- Reset, then MFC0 12 → 0x0040_0004; MFC0 15/sel1 → 0x8000_0000.
- MTC0 12 = 0xFFFF_FFFF, then MFC0 12 → 0x0040_FF07.
- exc_commit, exc_code=8, exc_epc=0xBFC0_0100, exc_bd=1, with EXL=0 → next cycle EPC=0xBFC0_0100, Cause=0x8000_0020, Status.EXL=1. A second exc_commit with exc_epc=0x1234 leaves EPC unchanged.
- exc_commit with badvaddr_we/context_we/entryhi_we, badvaddr_in=0x8000_2003, VPN2=0x40001 → BadVAddr=0x8000_2003, Context=0x0040_0010, EntryHi=0x8000_2000.
- Compare=5, Count=0, COUNT_DIV=1 → TI=1 and Cause[15]=1 about 10 cycles later; an MTC0 to Compare clears TI next cycle.
- exc_commit, eret and mtc0_we to Status in the same cycle → only the exception effects are applied. eret alone with ERL=1,EXL=1 → ERL=0, EXL=1.
